// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer: capacity, id widths,
// instruction kinds and per-entry metadata.
package reorder_buffer_pkg;

  localparam int ROB_CAP       = 16;
  localparam int ROB_INDEX_BIT = $clog2(ROB_CAP);

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_STORE  = 2'd2,
    KIND_OTHER  = 2'd3
  } rob_kind_e;

  typedef logic [ROB_INDEX_BIT-1:0]  rob_id_t;
  typedef logic [ROB_CAP-1:0][31:0]  rob_val_arr_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic        pred;
    logic [31:0] alt_pc;
  } rob_meta_t;

  localparam rob_id_t                ROB_ID_ONE   = {{(ROB_INDEX_BIT-1){1'b0}}, 1'b1};
  localparam logic [ROB_INDEX_BIT:0] ROB_CNT_ONE  = {{ROB_INDEX_BIT{1'b0}}, 1'b1};
  localparam logic [ROB_INDEX_BIT:0] ROB_CNT_FULL = (ROB_INDEX_BIT+1)'(ROB_CAP);

  function automatic rob_id_t rob_next(input rob_id_t id);
    return id + ROB_ID_ONE;
  endfunction

endpackage

// File: rtl/reorder_buffer_checker.sv
// Protocol checks on the reorder buffer write-back interface.
module rob_wb_checker
  import reorder_buffer_pkg::*;
(
  input logic    clk_in,
  input logic    rst_n_in,
  input logic    rdy_in,
  input logic    rs_ready,
  input rob_id_t rs_rob_id,
  input logic    lsb_ready,
  input rob_id_t lsb_rob_id
);

  // RS and LSB must never write back the same entry in one cycle.
  a_wb_unique: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    !(rdy_in && rs_ready && lsb_ready && (rs_rob_id == lsb_rob_id)));

endmodule

// File: rtl/reorder_buffer_query.sv
// Operand lookup into the reorder buffer with same-cycle write-back bypass.
module rob_operand_query
  import reorder_buffer_pkg::*;
(
  input  logic               wb_en,
  input  rob_id_t            qry_id,
  input  logic [ROB_CAP-1:0] busy,
  input  logic [ROB_CAP-1:0] done,
  input  rob_val_arr_t       value,
  input  logic               rs_ready,
  input  rob_id_t            rs_rob_id,
  input  logic [31:0]        rs_result,
  input  logic               lsb_ready,
  input  rob_id_t            lsb_rob_id,
  input  logic [31:0]        lsb_result,
  output logic               qry_rdy,
  output logic [31:0]        qry_val
);

  logic w_rs_hit;
  logic w_lsb_hit;

  assign w_rs_hit  = wb_en && busy[qry_id] && rs_ready  && (rs_rob_id  == qry_id);
  assign w_lsb_hit = wb_en && busy[qry_id] && lsb_ready && (lsb_rob_id == qry_id);

  // Stored result, overridden by a write-back landing on the same entry this cycle.
  always_comb begin
    qry_rdy = 1'b0;
    qry_val = 32'd0;
    if (w_rs_hit) begin
      qry_rdy = 1'b1;
      qry_val = rs_result;
    end else if (w_lsb_hit) begin
      qry_rdy = 1'b1;
      qry_val = lsb_result;
    end else begin
      qry_rdy = busy[qry_id] && done[qry_id];
      qry_val = value[qry_id];
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates ids at issue, collects write-backs and
// retires in order, broadcasting commits and flushing on branch mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        issue_req,
  input  logic [1:0]  issue_kind,
  input  logic [4:0]  issue_rd,
  input  logic        issue_pred,
  input  logic [31:0] issue_alt_pc,
  output rob_id_t     issue_rob_id,
  output logic        full,
  input  rob_id_t     qry1_id,
  input  rob_id_t     qry2_id,
  output logic        qry1_rdy,
  output logic        qry2_rdy,
  output logic [31:0] qry1_val,
  output logic [31:0] qry2_val,
  input  logic        rs_ready,
  input  rob_id_t     rs_rob_id,
  input  logic [31:0] rs_result,
  input  logic        lsb_ready,
  input  rob_id_t     lsb_rob_id,
  input  logic [31:0] lsb_result,
  output logic        cdb_req,
  output rob_id_t     cdb_rob_id,
  output logic [31:0] cdb_val,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_val,
  output rob_id_t     rf_rob_id,
  output logic        store_commit,
  output rob_id_t     store_rob_id,
  output logic        clear,
  output logic [31:0] clear_pc
);

  logic [ROB_CAP-1:0]     r_busy;
  logic [ROB_CAP-1:0]     r_done;
  rob_val_arr_t           r_value;
  rob_meta_t              r_meta [ROB_CAP];
  rob_id_t                r_head;
  rob_id_t                r_tail;
  logic [ROB_INDEX_BIT:0] r_count;
  logic                   r_full;

  rob_meta_t              w_head_meta;
  logic                   w_commit;
  logic                   w_mispredict;
  logic                   w_issue;
  logic [ROB_INDEX_BIT:0] w_next_count;

  assign w_head_meta  = r_meta[r_head];
  assign w_commit     = rdy_in && r_busy[r_head] && r_done[r_head];
  assign w_mispredict = w_commit && (w_head_meta.kind == KIND_BRANCH)
                        && (r_value[r_head][0] != w_head_meta.pred);
  // A commit frees the head slot, so a full buffer can still take an issue that cycle.
  assign w_issue      = rdy_in && issue_req && (!r_full || w_commit) && !w_mispredict;

  assign issue_rob_id = r_tail;
  assign full         = r_full;

  // Occupancy after this cycle's issue and commit.
  always_comb begin
    w_next_count = r_count;
    case ({w_issue, w_commit})
      2'b10:   w_next_count = r_count + ROB_CNT_ONE;
      2'b01:   w_next_count = r_count - ROB_CNT_ONE;
      default: w_next_count = r_count;
    endcase
  end

  // Entry storage and pointers; issue is applied last so it owns a slot freed this cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy  <= '0;
      r_done  <= '0;
      r_value <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      for (int i = 0; i < ROB_CAP; i++) begin
        r_meta[i] <= '0;
      end
    end else if (rdy_in) begin
      if (w_mispredict) begin
        r_busy  <= '0;
        r_done  <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_full  <= 1'b0;
      end else begin
        if (w_commit) begin
          r_busy[r_head] <= 1'b0;
          r_done[r_head] <= 1'b0;
          r_head         <= rob_next(r_head);
        end
        if (rs_ready && r_busy[rs_rob_id]) begin
          r_value[rs_rob_id] <= rs_result;
          r_done[rs_rob_id]  <= 1'b1;
        end
        if (lsb_ready && r_busy[lsb_rob_id]) begin
          r_value[lsb_rob_id] <= lsb_result;
          r_done[lsb_rob_id]  <= 1'b1;
        end
        if (w_issue) begin
          r_busy[r_tail] <= 1'b1;
          r_done[r_tail] <= 1'b0;
          r_meta[r_tail] <= {issue_kind, issue_rd, issue_pred, issue_alt_pc};
          r_tail         <= rob_next(r_tail);
        end
        r_count <= w_next_count;
        r_full  <= (w_next_count == ROB_CNT_FULL);
      end
    end
  end

  // Commit outputs; pulses are recomputed every active cycle and held while stalled.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cdb_req      <= 1'b0;
      cdb_rob_id   <= '0;
      cdb_val      <= 32'd0;
      rf_we        <= 1'b0;
      rf_rd        <= 5'd0;
      rf_val       <= 32'd0;
      rf_rob_id    <= '0;
      store_commit <= 1'b0;
      store_rob_id <= '0;
      clear        <= 1'b0;
      clear_pc     <= 32'd0;
    end else if (rdy_in) begin
      cdb_req      <= w_commit;
      rf_we        <= w_commit && (w_head_meta.kind == KIND_REG) && (w_head_meta.rd != 5'd0);
      store_commit <= w_commit && (w_head_meta.kind == KIND_STORE);
      clear        <= w_mispredict;
      if (w_commit) begin
        cdb_rob_id   <= r_head;
        cdb_val      <= r_value[r_head];
        rf_rd        <= w_head_meta.rd;
        rf_val       <= r_value[r_head];
        rf_rob_id    <= r_head;
        store_rob_id <= r_head;
      end
      if (w_mispredict) begin
        clear_pc <= w_head_meta.alt_pc;
      end
    end
  end

  rob_operand_query u_qry1 (
    .wb_en      (rdy_in),
    .qry_id     (qry1_id),
    .busy       (r_busy),
    .done       (r_done),
    .value      (r_value),
    .rs_ready   (rs_ready),
    .rs_rob_id  (rs_rob_id),
    .rs_result  (rs_result),
    .lsb_ready  (lsb_ready),
    .lsb_rob_id (lsb_rob_id),
    .lsb_result (lsb_result),
    .qry_rdy    (qry1_rdy),
    .qry_val    (qry1_val)
  );

  rob_operand_query u_qry2 (
    .wb_en      (rdy_in),
    .qry_id     (qry2_id),
    .busy       (r_busy),
    .done       (r_done),
    .value      (r_value),
    .rs_ready   (rs_ready),
    .rs_rob_id  (rs_rob_id),
    .rs_result  (rs_result),
    .lsb_ready  (lsb_ready),
    .lsb_rob_id (lsb_rob_id),
    .lsb_result (lsb_result),
    .qry_rdy    (qry2_rdy),
    .qry_val    (qry2_val)
  );

  rob_wb_checker u_chk (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .rdy_in     (rdy_in),
    .rs_ready   (rs_ready),
    .rs_rob_id  (rs_rob_id),
    .lsb_ready  (lsb_ready),
    .lsb_rob_id (lsb_rob_id)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized bench for reorder_buffer against a queue-based in-order retirement model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        issue_req;
  logic [1:0]  issue_kind;
  logic [4:0]  issue_rd;
  logic        issue_pred;
  logic [31:0] issue_alt_pc;
  rob_id_t     issue_rob_id;
  logic        full;
  rob_id_t     qry1_id, qry2_id;
  logic        qry1_rdy, qry2_rdy;
  logic [31:0] qry1_val, qry2_val;
  logic        rs_ready, lsb_ready;
  rob_id_t     rs_rob_id, lsb_rob_id;
  logic [31:0] rs_result, lsb_result;
  logic        cdb_req, rf_we, store_commit, clear;
  rob_id_t     cdb_rob_id, rf_rob_id, store_rob_id;
  logic [31:0] cdb_val, rf_val, clear_pc;
  logic [4:0]  rf_rd;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_req(issue_req), .issue_kind(issue_kind), .issue_rd(issue_rd),
    .issue_pred(issue_pred), .issue_alt_pc(issue_alt_pc),
    .issue_rob_id(issue_rob_id), .full(full),
    .qry1_id(qry1_id), .qry2_id(qry2_id), .qry1_rdy(qry1_rdy), .qry2_rdy(qry2_rdy),
    .qry1_val(qry1_val), .qry2_val(qry2_val),
    .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_result(rs_result),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_result(lsb_result),
    .cdb_req(cdb_req), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_val(rf_val), .rf_rob_id(rf_rob_id),
    .store_commit(store_commit), .store_rob_id(store_rob_id),
    .clear(clear), .clear_pc(clear_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          id;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic        pred;
    logic [31:0] alt_pc;
    bit          done;
    logic [31:0] value;
  } ment_t;

  ment_t mq[$];
  int    m_tail;
  int    n_checks = 0;
  int    n_fail   = 0;

  logic        e_cdb_req, e_rf_we, e_st, e_clr, e_full;
  int          e_cdb_id, e_rf_id, e_st_id;
  logic [31:0] e_cdb_val, e_rf_val, e_clr_pc;
  logic [4:0]  e_rf_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    {e_cdb_req, e_rf_we, e_st, e_clr, e_full} = '0;
    e_cdb_id = 0; e_rf_id = 0; e_st_id = 0;
    e_cdb_val = 0; e_rf_val = 0; e_clr_pc = 0; e_rf_rd = 0;
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; issue_req = 1'b0; issue_kind = KIND_REG; issue_rd = 5'd0;
    issue_pred = 1'b0; issue_alt_pc = 32'd0;
    rs_ready = 1'b0; rs_rob_id = '0; rs_result = 32'd0;
    lsb_ready = 1'b0; lsb_rob_id = '0; lsb_result = 32'd0;
    qry1_id = rob_id_t'($urandom_range(0, ROB_CAP-1));
    qry2_id = rob_id_t'($urandom_range(0, ROB_CAP-1));
  endtask

  task automatic model_qry(input int qid, output logic rdy, output logic [31:0] val);
    rdy = 1'b0; val = 32'd0;
    foreach (mq[i]) begin
      if (mq[i].id == qid) begin
        if (rs_ready && int'(rs_rob_id) == qid) begin rdy = 1'b1; val = rs_result; end
        else if (lsb_ready && int'(lsb_rob_id) == qid) begin rdy = 1'b1; val = lsb_result; end
        else if (mq[i].done) begin rdy = 1'b1; val = mq[i].value; end
      end
    end
  endtask

  task automatic model_step();
    bit commit, mis, was_full;
    ment_t h, n;
    if (!rdy_in) return;
    commit   = (mq.size() > 0) && mq[0].done;
    was_full = (mq.size() == ROB_CAP);
    mis = 1'b0;
    e_cdb_req = commit; e_rf_we = 1'b0; e_st = 1'b0; e_clr = 1'b0;
    if (commit) begin
      h = mq[0];
      e_cdb_id = h.id; e_cdb_val = h.value;
      e_rf_we = (h.kind == KIND_REG) && (h.rd != 5'd0);
      e_rf_rd = h.rd; e_rf_val = h.value; e_rf_id = h.id;
      e_st = (h.kind == KIND_STORE); e_st_id = h.id;
      mis = (h.kind == KIND_BRANCH) && (h.value[0] != h.pred);
      e_clr = mis;
      if (mis) e_clr_pc = h.alt_pc;
    end
    if (mis) begin
      mq.delete();
      m_tail = 0;
    end else begin
      if (commit) void'(mq.pop_front());
      foreach (mq[i]) begin
        if (rs_ready && int'(rs_rob_id) == mq[i].id) begin mq[i].done = 1; mq[i].value = rs_result; end
        if (lsb_ready && int'(lsb_rob_id) == mq[i].id) begin mq[i].done = 1; mq[i].value = lsb_result; end
      end
      if (issue_req && (!was_full || commit)) begin
        n.id = m_tail; n.kind = issue_kind; n.rd = issue_rd; n.pred = issue_pred;
        n.alt_pc = issue_alt_pc; n.done = 0; n.value = 32'd0;
        mq.push_back(n);
        m_tail = (m_tail + 1) % ROB_CAP;
      end
    end
    e_full = (mq.size() == ROB_CAP);
  endtask

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic step();
    logic r; logic [31:0] v;
    #1;
    check_eq("issue_rob_id", issue_rob_id, m_tail);
    if (rdy_in) begin
      model_qry(int'(qry1_id), r, v);
      check_eq("qry1_rdy", qry1_rdy, r);
      if (r) check_eq("qry1_val", qry1_val, v);
      model_qry(int'(qry2_id), r, v);
      check_eq("qry2_rdy", qry2_rdy, r);
      if (r) check_eq("qry2_val", qry2_val, v);
    end
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
    check_eq("cdb_req", cdb_req, e_cdb_req);
    check_eq("rf_we", rf_we, e_rf_we);
    check_eq("store_commit", store_commit, e_st);
    check_eq("clear", clear, e_clr);
    check_eq("full", full, e_full);
    if (e_cdb_req) begin
      check_eq("cdb_rob_id", cdb_rob_id, e_cdb_id);
      check_eq("cdb_val", cdb_val, e_cdb_val);
    end
    if (e_rf_we) begin
      check_eq("rf_rd", rf_rd, e_rf_rd);
      check_eq("rf_val", rf_val, e_rf_val);
      check_eq("rf_rob_id", rf_rob_id, e_rf_id);
    end
    if (e_st) check_eq("store_rob_id", store_rob_id, e_st_id);
    if (e_clr) check_eq("clear_pc", clear_pc, e_clr_pc);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"}, {cdb_req, rf_we, store_commit, clear, full, qry1_rdy, qry2_rdy}, 32'd0);
    check_eq({tag, "_ids"}, {cdb_rob_id, rf_rob_id, store_rob_id, issue_rob_id, rf_rd}, 32'd0);
    check_eq({tag, "_cdb_val"}, cdb_val, 32'd0);
    check_eq({tag, "_rf_val"}, rf_val, 32'd0);
    check_eq({tag, "_clear_pc"}, clear_pc, 32'd0);
    check_eq({tag, "_qry_val"}, qry1_val | qry2_val, 32'd0);
  endtask

  // Reset asserted between clock edges; outputs must drop without waiting for a clock.
  task automatic mid_reset(input string tag);
    idle_inputs();
    #2 rst_n_in = 1'b0;
    #1 check_all_zero(tag);
    @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    model_reset();
  endtask

  task automatic issue(input logic [1:0] k, input logic [4:0] rd, input logic p, input logic [31:0] pc);
    issue_req = 1'b1; issue_kind = k; issue_rd = rd; issue_pred = p; issue_alt_pc = pc;
  endtask

  task automatic rand_inputs();
    int nd[$]; int pick; int k;
    idle_inputs();
    rdy_in = ($urandom_range(0, 9) != 0);
    k = $urandom_range(0, 9);
    if ($urandom_range(0, 9) < 6)
      issue(k == 0 ? KIND_BRANCH : (k < 3 ? KIND_STORE : (k == 3 ? KIND_OTHER : KIND_REG)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
    foreach (mq[i]) if (!mq[i].done) nd.push_back(mq[i].id);
    if (nd.size() > 0 && $urandom_range(0, 1) == 1) begin
      pick = $urandom_range(0, nd.size() - 1);
      rs_ready = 1'b1; rs_rob_id = rob_id_t'(nd[pick]); rs_result = $urandom;
      nd.delete(pick);
    end
    if (nd.size() > 0 && $urandom_range(0, 2) == 0) begin
      pick = $urandom_range(0, nd.size() - 1);
      lsb_ready = 1'b1; lsb_rob_id = rob_id_t'(nd[pick]); lsb_result = $urandom;
    end else if ($urandom_range(0, 15) == 0) begin
      lsb_ready = 1'b1; lsb_rob_id = rs_rob_id + ROB_ID_ONE; lsb_result = $urandom;
    end
  endtask

  initial begin
    int sid;
    rst_n_in = 1'b0;
    idle_inputs();
    model_reset();
    #2 check_all_zero("reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // three register ops receive ids 0,1,2 and wait for their results
    for (int i = 1; i <= 3; i++) begin idle_inputs(); issue(KIND_REG, 5'(i), 1'b0, 32'd0); step(); end
    idle_inputs(); step();
    // out-of-order write-backs retire in order
    idle_inputs(); rs_ready = 1'b1; rs_rob_id = 4'd1; rs_result = 32'd7; step();
    idle_inputs(); lsb_ready = 1'b1; lsb_rob_id = 4'd0; lsb_result = 32'd5; step();
    for (int i = 0; i < 3; i++) begin idle_inputs(); step(); end

    // fill to capacity, overflow issue dropped, then commit+issue while full
    for (int i = 0; i < ROB_CAP + 1; i++) begin idle_inputs(); issue(KIND_OTHER, 5'd9, 1'b0, 32'd0); step(); end
    idle_inputs(); rs_ready = 1'b1; rs_rob_id = rob_id_t'(mq[0].id); rs_result = 32'h55; step();
    idle_inputs(); issue(KIND_REG, 5'd4, 1'b0, 32'd0); step();
    idle_inputs(); step();

    // mispredicted branch at head flushes a younger completed entry
    mid_reset("reset_mid");
    idle_inputs(); issue(KIND_BRANCH, 5'd0, 1'b1, 32'h100); step();
    idle_inputs(); issue(KIND_REG, 5'd5, 1'b0, 32'd0); step();
    idle_inputs(); rs_ready = 1'b1; rs_rob_id = 4'd1; rs_result = 32'd9; step();
    idle_inputs(); lsb_ready = 1'b1; lsb_rob_id = 4'd0; lsb_result = 32'd0; step();
    for (int i = 0; i < 3; i++) begin idle_inputs(); step(); end

    // store and rd=0 register commit without register-file write
    idle_inputs(); issue(KIND_STORE, 5'd3, 1'b0, 32'd0); step();
    idle_inputs(); issue(KIND_REG, 5'd0, 1'b0, 32'd0); step();
    idle_inputs(); rs_ready = 1'b1; rs_rob_id = 4'd0; rs_result = 32'hABC;
    lsb_ready = 1'b1; lsb_rob_id = 4'd1; lsb_result = 32'hDEF; step();
    for (int i = 0; i < 3; i++) begin idle_inputs(); step(); end

    // stalled head stays uncommitted while rdy_in is low
    sid = m_tail;
    idle_inputs(); issue(KIND_REG, 5'd7, 1'b0, 32'd0); step();
    idle_inputs(); rs_ready = 1'b1; rs_rob_id = rob_id_t'(sid); rs_result = 32'h77; step();
    for (int i = 0; i < 3; i++) begin idle_inputs(); rdy_in = 1'b0; step(); end
    for (int i = 0; i < 3; i++) begin idle_inputs(); step(); end

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) mid_reset("reset_rand");
      rand_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
